rob_multifill: RTL
==================

Name: rob_multifill

Overview:
- Parametrised reorder buffer for the out-of-order core.
- Books entries in program order from the register manager and accepts results from NUM_FILL execution channels in the same cycle.
- Retires at most one instruction per cycle and broadcasts the commit outcome: fault, misspeculation and recovery PC.
- Flushes all younger entries on a faulting or misspeculated commit.

Parameters:
DEPTH, 16, number of ROB entries (power of two, >=2)
NUM_FILL, 2, number of independent result-fill channels
DATA_W, 32, destination register data width
PC_W, 32, program counter width
PVL_W, 2, privilege field width
AREG_W, 5, architectural register index width
TRAP_W, 4, trap cause width; 0 = no trap
IDX_W (localparam), clog2(DEPTH+1), tag width; tag = slot+1, tag 0 = none

Ports:
c_clock  in  1  clock, rising edge
c_reset  in  1  asynchronous active-high reset
c_pause  in  1  blocks booking and commit; fills still captured
c_req  in  1  book request
i_areg_rd  in  AREG_W  arch destination of booked instr (0 = none)
i_pc / i_pvl  in  PC_W / PVL_W  PC and privilege of booked instr
i_spec_pc / i_spec_pvl  in  PC_W / PVL_W  speculated next PC and privilege
s_book  out  1  booking accepted this cycle (combinational)
i_preg_rd  out  IDX_W  tag of booked entry; valid when s_book=1
f_valid  in  NUM_FILL  per-channel fill strobe
f_tag  in  NUM_FILL*IDX_W  target tag per channel
f_data  in  NUM_FILL*DATA_W  result data
f_next_pc / f_next_pvl  in  NUM_FILL*PC_W / NUM_FILL*PVL_W  resolved next PC and privilege
f_trapc  in  NUM_FILL*TRAP_W  trap cause
s_enable  out  1  commit broadcast valid (registered)
s_cur  out  1  committed instr fault-free
s_cur_fcode  out  TRAP_W  trap cause of committed instr
s_spec  out  1  speculation correct
recov_pc / recov_pvl  out  PC_W / PVL_W  resolved next PC and privilege
cur_pc / cur_pvl  out  PC_W / PVL_W  PC and privilege of committed instr
c_areg_rd / c_data  out  AREG_W / DATA_W  arch write-back target and data
s_count  out  IDX_W  occupied entries

Behaviour:
- Reset (asynchronous):
  - head=tail=0, count=0, all valid/done bits cleared.
  - All registered outputs 0; s_enable=0.
- Entry fields: valid, done, areg, pc, pvl, spec_pc, spec_pvl, data, next_pc, next_pvl, trapc.
- Booking:
  - s_book = c_req & !c_pause & (count<DEPTH) & !flush_now.
  - i_preg_rd = tail+1 combinationally.
  - On the edge with s_book=1: the entry is written with valid=1, done=0, and tail increments modulo DEPTH.
- Fill:
  - Channel k is accepted when f_valid[k]=1, tag!=0 and the entry at tag-1 is valid and not done.
  - Accepted fill writes data, next_pc, next_pvl and trapc, and sets done on the same edge.
  - Fills are captured even when c_pause=1.
  - If two channels target the same tag, the lowest-index channel wins and the others are dropped.
  - Fills to tag 0, to invalid entries, or to done entries are ignored.
  - Fill and commit of the same entry never coincide: commit requires done to be set before the edge.
- Commit:
  - Commit fires when head valid & done & !c_pause at the rising edge.
  - Head is popped and outputs are registered for one cycle: s_enable=1, s_cur=(trapc==0), s_cur_fcode=trapc, s_spec=({next_pc,next_pvl}=={spec_pc,spec_pvl}), recov_*=next_*, cur_*=pc/pvl, c_areg_rd, c_data.
  - Otherwise s_enable=0 and the other commit outputs hold their previous values.
  - Latency: fill edge -> earliest commit edge is 1 cycle; commit outputs are visible after that edge.
- Flush:
  - flush_now = commit condition & (trapc!=0 | speculation mismatch).
  - On that edge all entries are invalidated and head=tail=count=0.
  - A concurrent book is refused (s_book=0); concurrent fills are discarded.
- Count:
  - count += s_book − commit, except flush forces count to 0.
  - At count==DEPTH, s_book=0 even if a commit occurs on the same edge.
- Pointers wrap modulo DEPTH; tags stay 1..DEPTH across wrap.
- Reset asserted mid-operation clears state immediately; the first book after release gets tag 1.

Test Plan:
- Reset, book 3 instrs (pc 0x100,0x104,0x108, spec next = pc+4) -> tags 1,2,3; s_count=3.
- Fill tags 3,1,2 on alternating channels with next = pc+4, trapc=0 -> three consecutive s_enable pulses in order cur_pc 0x100,0x104,0x108; all with s_cur=1, s_spec=1.
- Book DEPTH=16 entries with c_req held high -> s_book=0 on the 17th request; commit head; the next book returns tag 1 (wrap).
- Book 4 entries; fill tag1 with next_pc 0x200 against spec 0x104 -> commit with s_spec=0, recov_pc=0x200; s_count=0 next cycle; a later fill to tag 2 is ignored.
- Both channels fill tag 2 in the same cycle with data 0xAA (ch0) and 0xBB (ch1) -> c_data=0xAA at commit; a fill with trapc=5 gives s_cur=0, s_cur_fcode=5 and a flush.
- Hold c_pause with head done -> no commit and no book, but a fill to tag 2 is still recorded; release -> commits resume. Assert c_reset mid-stream -> s_count=0 and s_enable=0 immediately.

Source files
------------

// File: rtl/rob_multifill_if.sv
// Book / fill / commit bundle of the reorder buffer.
// The core side (booking, execution channels) is the master; the ROB is the slave.
interface rob_multifill_if #(
  parameter int DEPTH    = 16,
  parameter int NUM_FILL = 2,
  parameter int DATA_W   = 32,
  parameter int PC_W     = 32,
  parameter int PVL_W    = 2,
  parameter int AREG_W   = 5,
  parameter int TRAP_W   = 4
);
  localparam int IDX_W = $clog2(DEPTH + 1);

  // control and booking
  logic                               c_pause;
  logic                               c_req;
  logic [AREG_W-1:0]                  i_areg_rd;
  logic [PC_W-1:0]                    i_pc;
  logic [PVL_W-1:0]                   i_pvl;
  logic [PC_W-1:0]                    i_spec_pc;
  logic [PVL_W-1:0]                   i_spec_pvl;
  logic                               s_book;
  logic [IDX_W-1:0]                   i_preg_rd;
  // result fill channels
  logic [NUM_FILL-1:0]                f_valid;
  logic [NUM_FILL-1:0][IDX_W-1:0]     f_tag;
  logic [NUM_FILL-1:0][DATA_W-1:0]    f_data;
  logic [NUM_FILL-1:0][PC_W-1:0]      f_next_pc;
  logic [NUM_FILL-1:0][PVL_W-1:0]     f_next_pvl;
  logic [NUM_FILL-1:0][TRAP_W-1:0]    f_trapc;
  // commit broadcast
  logic                               s_enable;
  logic                               s_cur;
  logic [TRAP_W-1:0]                  s_cur_fcode;
  logic                               s_spec;
  logic [PC_W-1:0]                    recov_pc;
  logic [PVL_W-1:0]                   recov_pvl;
  logic [PC_W-1:0]                    cur_pc;
  logic [PVL_W-1:0]                   cur_pvl;
  logic [AREG_W-1:0]                  c_areg_rd;
  logic [DATA_W-1:0]                  c_data;
  logic [IDX_W-1:0]                   s_count;

  modport master (
    output c_pause, c_req, i_areg_rd, i_pc, i_pvl, i_spec_pc, i_spec_pvl,
           f_valid, f_tag, f_data, f_next_pc, f_next_pvl, f_trapc,
    input  s_book, i_preg_rd, s_enable, s_cur, s_cur_fcode, s_spec,
           recov_pc, recov_pvl, cur_pc, cur_pvl, c_areg_rd, c_data, s_count
  );

  modport slave (
    input  c_pause, c_req, i_areg_rd, i_pc, i_pvl, i_spec_pc, i_spec_pvl,
           f_valid, f_tag, f_data, f_next_pc, f_next_pvl, f_trapc,
    output s_book, i_preg_rd, s_enable, s_cur, s_cur_fcode, s_spec,
           recov_pc, recov_pvl, cur_pc, cur_pvl, c_areg_rd, c_data, s_count
  );
endinterface

// File: rtl/rob_multifill.sv
// Reorder buffer: in-order booking, NUM_FILL parallel result fills,
// single in-order commit with fault / misspeculation flush.
// Tags are slot+1 so that tag 0 can mean "no destination".
module rob_multifill #(
  parameter int DEPTH    = 16,
  parameter int NUM_FILL = 2,
  parameter int DATA_W   = 32,
  parameter int PC_W     = 32,
  parameter int PVL_W    = 2,
  parameter int AREG_W   = 5,
  parameter int TRAP_W   = 4
) (
  input  logic            c_clock,
  input  logic            c_reset,
  rob_multifill_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  // fields written at booking time
  typedef struct packed {
    logic [AREG_W-1:0] areg;
    logic [PC_W-1:0]   pc;
    logic [PVL_W-1:0]  pvl;
    logic [PC_W-1:0]   spec_pc;
    logic [PVL_W-1:0]  spec_pvl;
  } book_t;

  // fields written by a fill
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [PC_W-1:0]   next_pc;
    logic [PVL_W-1:0]  next_pvl;
    logic [TRAP_W-1:0] trapc;
  } res_t;

  book_t             bk_q [DEPTH];
  res_t              rs_q [DEPTH];
  logic [DEPTH-1:0]  vld_q, done_q;
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [IDX_W-1:0]  count_q;

  logic                           commit, spec_ok, flush_now;
  logic [NUM_FILL-1:0]            fill_hit, fill_acc;
  logic [NUM_FILL-1:0][PTR_W-1:0] fill_slot;

  // per-channel fill decode; a lower channel aimed at the same tag wins
  for (genvar k = 0; k < NUM_FILL; k++) begin : g_fill
    logic [IDX_W-1:0] tag_k;
    logic             acc;
    assign tag_k        = bus.f_tag[k];
    assign fill_slot[k] = PTR_W'(tag_k - IDX_W'(1));
    assign fill_hit[k]  = bus.f_valid[k] && (tag_k != '0) && (tag_k <= IDX_W'(DEPTH)) &&
                          vld_q[fill_slot[k]] && !done_q[fill_slot[k]];
    // drop this channel if any lower channel already hits the same tag
    always_comb begin
      acc = fill_hit[k];
      for (int j = 0; j < k; j++)
        if (fill_hit[j] && bus.f_tag[j] == tag_k) acc = 1'b0;
    end
    assign fill_acc[k] = acc;
  end

  // head retires only if done before the edge; bad outcome squashes the whole buffer
  assign commit    = vld_q[head_q] && done_q[head_q] && !bus.c_pause;
  assign spec_ok   = {rs_q[head_q].next_pc, rs_q[head_q].next_pvl} ==
                     {bk_q[head_q].spec_pc, bk_q[head_q].spec_pvl};
  assign flush_now = commit && ((rs_q[head_q].trapc != '0) || !spec_ok);

  assign bus.s_book    = bus.c_req && !bus.c_pause && (count_q != IDX_W'(DEPTH)) && !flush_now;
  assign bus.i_preg_rd = IDX_W'(tail_q) + IDX_W'(1);
  assign bus.s_count   = count_q;

  // occupancy state: pointers, count, valid/done bits
  always_ff @(posedge c_clock or posedge c_reset) begin
    if (c_reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
      done_q  <= '0;
    end else if (flush_now) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
      done_q  <= '0;
    end else begin
      if (bus.s_book) begin
        vld_q[tail_q]  <= 1'b1;
        done_q[tail_q] <= 1'b0;
        tail_q         <= tail_q + PTR_W'(1);
      end
      for (int k = 0; k < NUM_FILL; k++)
        if (fill_acc[k]) done_q[fill_slot[k]] <= 1'b1;
      if (commit) begin
        vld_q[head_q]  <= 1'b0;
        done_q[head_q] <= 1'b0;
        head_q         <= head_q + PTR_W'(1);
      end
      count_q <= count_q + IDX_W'(bus.s_book) - IDX_W'(commit);
    end
  end

  // entry payload; only meaningful while the valid bit is set, so no reset
  always_ff @(posedge c_clock) begin
    if (bus.s_book)
      bk_q[tail_q] <= {bus.i_areg_rd, bus.i_pc, bus.i_pvl, bus.i_spec_pc, bus.i_spec_pvl};
    for (int k = 0; k < NUM_FILL; k++)
      if (fill_acc[k])
        rs_q[fill_slot[k]] <= {bus.f_data[k], bus.f_next_pc[k], bus.f_next_pvl[k], bus.f_trapc[k]};
  end

  // registered commit broadcast; payload holds between commits
  always_ff @(posedge c_clock or posedge c_reset) begin
    if (c_reset) begin
      bus.s_enable    <= 1'b0;
      bus.s_cur       <= 1'b0;
      bus.s_cur_fcode <= '0;
      bus.s_spec      <= 1'b0;
      bus.recov_pc    <= '0;
      bus.recov_pvl   <= '0;
      bus.cur_pc      <= '0;
      bus.cur_pvl     <= '0;
      bus.c_areg_rd   <= '0;
      bus.c_data      <= '0;
    end else begin
      bus.s_enable <= commit;
      if (commit) begin
        bus.s_cur       <= (rs_q[head_q].trapc == '0);
        bus.s_cur_fcode <= rs_q[head_q].trapc;
        bus.s_spec      <= spec_ok;
        bus.recov_pc    <= rs_q[head_q].next_pc;
        bus.recov_pvl   <= rs_q[head_q].next_pvl;
        bus.cur_pc      <= bk_q[head_q].pc;
        bus.cur_pvl     <= bk_q[head_q].pvl;
        bus.c_areg_rd   <= bk_q[head_q].areg;
        bus.c_data      <= rs_q[head_q].data;
      end
    end
  end
endmodule
